apu_cfg_sequencer: RTL and testbench



---
 rtl/apu_cfg_pkg.sv | 21 ++
 rtl/cfg_timeout_timer.sv | 30 +++
 rtl/apu_cfg_sequencer.sv | 167 ++++++++++++++++
 tb/tb_apu_cfg_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_cfg_pkg.sv
// Shared types and field constants for the APU configuration sequencer.
package apu_cfg_pkg;

  // Command assembly state: waiting for a low nibble, or holding one.
  typedef enum logic {
    IDLE    = 1'b0,
    HAVE_LO = 1'b1
  } state_t;

  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;

  // Field layout of a received command byte.
  localparam int IDX_MSB  = 7;
  localparam int IDX_LSB  = 5;
  localparam int NSEL_BIT = 4;

  // Register sub-address (low two index bits) that starts a channel.
  localparam logic [1:0] TRIG_SUBADDR = 2'b11;

endpackage

// File: rtl/cfg_timeout_timer.sv
// Loadable down-counter that flags when the low/high nibble window has run out.
module cfg_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 40000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_reg;

  // Load wins over counting; the count parks at zero once it gets there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= RELOAD;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/apu_cfg_sequencer.sv
// Assembles nibble-pair UART bytes into APU register writes, shadows the
// register file, pulses channel triggers and counts rejected sequences.
module apu_cfg_sequencer
  import apu_cfg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40000,
  parameter int ERR_W          = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    reg_we,
  output logic [REG_AW-1:0]       reg_addr,
  output logic [7:0]              reg_wdata,
  output logic [8*NUM_REGS-1:0]   regs,
  output logic [1:0]              trigger,
  output logic                    busy,
  output logic [ERR_W-1:0]        err_count
);

  state_t state_reg, state_next;

  logic [REG_AW-1:0] lo_idx_reg;
  logic [3:0]        lo_nib_reg;
  logic              reg_we_reg;
  logic [REG_AW-1:0] reg_addr_reg;
  logic [7:0]        reg_wdata_reg;
  logic [1:0]        trigger_reg;
  logic [ERR_W-1:0]  err_count_reg;

  logic              do_write;
  logic              err_inc;
  logic              latch_lo;
  logic              timer_expired;

  logic [REG_AW-1:0] rx_idx;
  logic              rx_is_hi;
  logic [3:0]        rx_nib;
  logic [7:0]        wdata_next;

  assign rx_idx     = rx_data[IDX_MSB:IDX_LSB];
  assign rx_is_hi   = rx_data[NSEL_BIT];
  assign rx_nib     = rx_data[NSEL_BIT-1:0];
  assign wdata_next = {rx_nib, lo_nib_reg};

  cfg_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (latch_lo),
    .enable (busy),
    .expired(timer_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and per-byte decisions; a byte always takes priority over expiry.
  always_comb begin
    state_next = state_reg;
    do_write   = 1'b0;
    err_inc    = 1'b0;
    latch_lo   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rx_valid) begin
          if (rx_is_hi) begin
            err_inc = 1'b1;
          end else begin
            latch_lo   = 1'b1;
            state_next = HAVE_LO;
          end
        end
      end
      HAVE_LO: begin
        if (rx_valid) begin
          if (!rx_is_hi) begin
            err_inc  = 1'b1;
            latch_lo = 1'b1;
          end else if (rx_idx == lo_idx_reg) begin
            do_write   = 1'b1;
            state_next = IDLE;
          end else begin
            err_inc    = 1'b1;
            state_next = IDLE;
          end
        end else if (timer_expired) begin
          err_inc    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the pending register index and low nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_idx_reg <= '0;
      lo_nib_reg <= '0;
    end else if (latch_lo) begin
      lo_idx_reg <= rx_idx;
      lo_nib_reg <= rx_nib;
    end
  end

  // Write port and trigger pulses, registered one cycle after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_we_reg    <= 1'b0;
      reg_addr_reg  <= '0;
      reg_wdata_reg <= '0;
      trigger_reg   <= '0;
    end else begin
      reg_we_reg  <= do_write;
      trigger_reg <= '0;
      if (do_write) begin
        reg_addr_reg  <= lo_idx_reg;
        reg_wdata_reg <= wdata_next;
        if (lo_idx_reg[1:0] == TRIG_SUBADDR) begin
          trigger_reg[lo_idx_reg[2]] <= 1'b1;
        end
      end
    end
  end

  // Saturating count of rejected sequences.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_reg <= '0;
    end else if (err_inc && (err_count_reg != {ERR_W{1'b1}})) begin
      err_count_reg <= err_count_reg + 1'b1;
    end
  end

  // One shadow byte per APU register, packed onto the flat regs bus.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_shadow
    logic [7:0] data_reg;

    // Update this byte when the accepted write targets it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_reg <= '0;
      end else if (do_write && (lo_idx_reg == REG_AW'(gi))) begin
        data_reg <= wdata_next;
      end
    end

    assign regs[8*gi +: 8] = data_reg;
  end

  assign reg_we    = reg_we_reg;
  assign reg_addr  = reg_addr_reg;
  assign reg_wdata = reg_wdata_reg;
  assign trigger   = trigger_reg;
  assign busy      = (state_reg == HAVE_LO);
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_apu_cfg_sequencer.sv
// Bench for apu_cfg_sequencer: a cycle-level reference model plus directed
// scenarios with hand-computed register, error and pulse-count expectations.
// The nibble window is shortened so the timeout cases stay quick.
module tb_apu_cfg_sequencer;

  localparam int TO  = 1000;
  localparam int GAP = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        reg_we;
  logic [2:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic [63:0] regs;
  logic [1:0]  trigger;
  logic        busy;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  apu_cfg_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .ERR_W         (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .reg_we   (reg_we),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .regs     (regs),
    .trigger  (trigger),
    .busy     (busy),
    .err_count(err_count)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the pending low nibble with the cycle it arrived on; the high
  // nibble is on time while no more than TO cycles have elapsed since then.
  bit         m_pend;
  logic [2:0] m_idx;
  logic [3:0] m_nib;
  int         m_t0;
  int         cyc;
  logic [7:0] m_regs [8];
  int         m_err;
  bit         m_we;
  logic [2:0] m_addr;
  logic [7:0] m_wdata;
  logic [1:0] m_trig;

  task automatic bump_err();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_step();
    logic [2:0] idx;
    logic [3:0] nib;
    if (!rst_n) begin
      m_pend = 0; m_idx = 0; m_nib = 0; m_t0 = 0;
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      m_err = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_trig = 0;
    end else begin
      cyc++;
      m_we   = 0;
      m_trig = 0;
      if (rx_valid) begin
        idx = rx_data[7:5];
        nib = rx_data[3:0];
        if (!rx_data[4]) begin
          if (m_pend) bump_err();
          m_pend = 1; m_idx = idx; m_nib = nib; m_t0 = cyc;
        end else if (m_pend && idx == m_idx) begin
          m_pend = 0;
          m_we = 1; m_addr = idx; m_wdata = {nib, m_nib};
          m_regs[idx] = m_wdata;
          if (idx == 3'd3) m_trig = 2'b01;
          else if (idx == 3'd7) m_trig = 2'b10;
        end else begin
          bump_err();
          m_pend = 0;
        end
      end else if (m_pend && (cyc - m_t0) >= TO) begin
        bump_err();
        m_pend = 0;
      end
    end
  endtask

  function automatic logic [63:0] pack_model();
    logic [63:0] p;
    for (int i = 0; i < 8; i++) p[8*i +: 8] = m_regs[i];
    return p;
  endfunction

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  // ---------------- per-cycle compare and pulse counting ----------------
  int we_cnt = 0, t0_cnt = 0, t1_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("cyc_reg_we",    64'(reg_we),    64'(m_we));
        chk("cyc_reg_addr",  64'(reg_addr),  64'(m_addr));
        chk("cyc_reg_wdata", 64'(reg_wdata), 64'(m_wdata));
        chk("cyc_regs",      regs,           pack_model());
        chk("cyc_trigger",   64'(trigger),   64'(m_trig));
        chk("cyc_busy",      64'(busy),      64'(m_pend));
        chk("cyc_err_count", 64'(err_count), 64'(m_err));
        if (reg_we)     we_cnt++;
        if (trigger[0]) t0_cnt++;
        if (trigger[1]) t1_cnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] seq1 [8] = '{8'h27, 8'h3A, 8'h02, 8'h18, 8'h4C, 8'h57, 8'h69, 8'h70};
  logic [7:0] seq2 [8] = '{8'h2B, 8'h3C, 8'h0F, 8'h19, 8'h4F, 8'h5E, 8'h68, 8'h70};
  int we_base, t0_base, t1_base;

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    we_base = we_cnt;
    t0_base = t0_cnt;
    t1_base = t1_cnt;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    snap();
  endtask

  function automatic logic [63:0] rbyte(input int n);
    return 64'(regs[8*n +: 8]);
  endfunction

  initial begin
    idle(3);
    rst_n = 1'b1;
    idle(1);
    chk("rst_regs",  regs, 64'h0);
    chk("rst_err",   64'(err_count), 64'h0);
    chk("rst_busy",  64'(busy), 64'h0);
    chk("rst_we",    64'(reg_we), 64'h0);
    chk("rst_trig",  64'(trigger), 64'h0);
    chk("rst_addr",  64'(reg_addr), 64'h0);
    chk("rst_wdata", 64'(reg_wdata), 64'h0);
    snap();

    // Scenario 1: four spaced pairs, reg 3 triggers square1.
    foreach (seq1[i]) begin send(seq1[i]); idle(GAP); end
    chk("s1_reg0", rbyte(0), 64'h82);
    chk("s1_reg1", rbyte(1), 64'hA7);
    chk("s1_reg2", rbyte(2), 64'h7C);
    chk("s1_reg3", rbyte(3), 64'h09);
    chk("s1_err",  64'(err_count), 64'h0);
    chk("s1_we_pulses", 64'(we_cnt - we_base), 64'd4);
    chk("s1_trig0_pulses", 64'(t0_cnt - t0_base), 64'd1);
    chk("s1_model_reg1", 64'(m_regs[1]), 64'hA7);

    // Scenario 2: different data, square2 never fires.
    do_reset();
    foreach (seq2[i]) begin send(seq2[i]); idle(GAP); end
    chk("s2_reg0", rbyte(0), 64'h9F);
    chk("s2_reg1", rbyte(1), 64'hCB);
    chk("s2_reg2", rbyte(2), 64'hEF);
    chk("s2_reg3", rbyte(3), 64'h08);
    chk("s2_trig0_pulses", 64'(t0_cnt - t0_base), 64'd1);
    chk("s2_trig1_pulses", 64'(t1_cnt - t1_base), 64'd0);

    // Scenario 3: reg 7 write triggers square2, then an orphan high nibble.
    do_reset();
    send(8'hEA); idle(GAP); send(8'hF5); idle(GAP);
    chk("s3_reg7", rbyte(7), 64'h5A);
    chk("s3_trig1_pulses", 64'(t1_cnt - t1_base), 64'd1);
    chk("s3_model_reg7", 64'(m_regs[7]), 64'h5A);
    send(8'h3A); idle(GAP);
    chk("s3_orphan_err", 64'(err_count), 64'h1);
    chk("s3_we_pulses", 64'(we_cnt - we_base), 64'd1);

    // Scenario 4: high nibble one cycle too late -> timeout, then orphan.
    do_reset();
    send(8'h27); idle(TO);
    chk("s4_busy_after_to", 64'(busy), 64'h0);
    chk("s4_err_after_to",  64'(err_count), 64'h1);
    send(8'h3A); idle(3);
    chk("s4_err", 64'(err_count), 64'h2);
    chk("s4_reg1", rbyte(1), 64'h0);
    chk("s4_we_pulses", 64'(we_cnt - we_base), 64'd0);

    // Scenario 5: high nibble on the exact expiry cycle is still on time.
    do_reset();
    send(8'h27); idle(TO - 1);
    chk("s5_busy_at_edge", 64'(busy), 64'h1);
    send(8'h3A); idle(3);
    chk("s5_reg1", rbyte(1), 64'hA7);
    chk("s5_err",  64'(err_count), 64'h0);
    chk("s5_we_pulses", 64'(we_cnt - we_base), 64'd1);

    // Scenario 6: abandoned low nibble, then index mismatch.
    do_reset();
    send(8'h27); idle(GAP); send(8'h4C); idle(GAP); send(8'h57); idle(GAP);
    chk("s6_err", 64'(err_count), 64'h1);
    chk("s6_reg2", rbyte(2), 64'h7C);
    chk("s6_reg1", rbyte(1), 64'h0);
    send(8'h27); idle(GAP); send(8'h5A); idle(GAP);
    chk("s6_mismatch_err", 64'(err_count), 64'h2);
    chk("s6_we_pulses", 64'(we_cnt - we_base), 64'd1);
    chk("s6_reg2_kept", rbyte(2), 64'h7C);

    // Scenario 7: back-to-back bytes on consecutive cycles.
    do_reset();
    send(8'h27); send(8'h3A); send(8'h02); send(8'h18); idle(3);
    chk("s7_reg1", rbyte(1), 64'hA7);
    chk("s7_reg0", rbyte(0), 64'h82);
    chk("s7_we_pulses", 64'(we_cnt - we_base), 64'd2);
    chk("s7_err", 64'(err_count), 64'h0);

    // Scenario 8: reset while holding a low nibble discards it.
    do_reset();
    send(8'h27); idle(2);
    chk("s8_busy_pending", 64'(busy), 64'h1);
    do_reset();
    chk("s8_busy_after_rst", 64'(busy), 64'h0);
    send(8'h3A); idle(3);
    chk("s8_err", 64'(err_count), 64'h1);
    chk("s8_reg1", rbyte(1), 64'h0);
    chk("s8_we_pulses", 64'(we_cnt - we_base), 64'd0);

    // Scenario 9: 300 orphans saturate the error counter.
    do_reset();
    for (int i = 0; i < 300; i++) send(8'h3A);
    idle(3);
    chk("s9_err_sat", 64'(err_count), 64'hFF);
    chk("s9_we_pulses", 64'(we_cnt - we_base), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
